// File: rtl/queue_sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : queue_sensor_ctrl
//  Description : Debounces the entry/exit photocells of a service queue,
//                buffers detected passages in small pending counters and
//                drives an up/down queue counter through a one-cycle strobe
//                framed by SETUP and HOLD cycles. Exits are served first.
//  Revision    : 1.0 - initial release
// ============================================================================
module queue_sensor_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int PEND_W    = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic front_pcell,
    input  logic back_pcell,
    input  logic full,
    input  logic empty,
    output logic count,
    output logic up_down,
    output logic busy,
    output logic drop_err
);

    localparam logic [3:0]        c_run_last = 4'(DB_CYCLES - 1);
    localparam logic [PEND_W-1:0] c_pend_max = {PEND_W{1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Index 0 is the entry cell, index 1 the exit cell.
    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic [1:0] w_pend_nz;
    logic [1:0] w_take;
    logic [1:0] w_sat_drop;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_sel_entry;
    logic       w_sel_exit;
    logic       w_sel_blocked;
    logic       w_count_nxt;
    logic       w_up_down_nxt;
    logic       w_drop_nxt;

    assign w_raw = {back_pcell, front_pcell};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_cell
            logic              r_sync1;
            logic              r_sync2;
            logic              r_deb;
            logic              r_deb_q;
            logic [3:0]        r_run;
            logic [PEND_W-1:0] r_pend;
            logic              w_full_cnt;

            assign w_full_cnt    = (r_pend == c_pend_max);
            assign w_rise[i]     = r_deb & ~r_deb_q;
            assign w_pend_nz[i]  = |r_pend;
            // A new event is lost only when the counter is full and nothing is taken out this cycle.
            assign w_sat_drop[i] = w_rise[i] & ~w_take[i] & w_full_cnt;

            // Synchronize the raw cell and accept a new level only after a stable run.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_q <= 1'b0;
                    r_run   <= 4'd0;
                end else begin
                    r_sync1 <= w_raw[i];
                    r_sync2 <= r_sync1;
                    r_deb_q <= r_deb;
                    if (r_sync2 == r_deb) begin
                        r_run <= 4'd0;
                    end else if (r_run == c_run_last) begin
                        r_deb <= ~r_deb;
                        r_run <= 4'd0;
                    end else begin
                        r_run <= r_run + 4'd1;
                    end
                end
            end

            // Count debounced passages waiting for service; simultaneous add and take cancel.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pend <= '0;
                end else if (w_rise[i] && !w_take[i]) begin
                    if (!w_full_cnt) begin
                        r_pend <= r_pend + 1'b1;
                    end
                end else if (!w_rise[i] && w_take[i]) begin
                    r_pend <= r_pend - 1'b1;
                end
            end
        end
    endgenerate

    // Exit requests win over entry requests; full/empty only matter at selection.
    assign w_sel_exit    = (r_state == S_IDLE) & w_pend_nz[1];
    assign w_sel_entry   = (r_state == S_IDLE) & ~w_pend_nz[1] & w_pend_nz[0];
    assign w_take        = {w_sel_exit, w_sel_entry};
    assign w_sel_blocked = (w_sel_entry & full) | (w_sel_exit & empty);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a blocked selection is consumed but stays in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((w_sel_entry || w_sel_exit) && !w_sel_blocked) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: w_state_nxt = S_PULSE;
            S_PULSE: w_state_nxt = S_HOLD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: direction loads only when leaving IDLE, strobe follows PULSE.
    always_comb begin
        w_count_nxt   = (w_state_nxt == S_PULSE);
        w_up_down_nxt = up_down;
        if (r_state == S_IDLE && w_state_nxt == S_SETUP) begin
            w_up_down_nxt = w_sel_entry;
        end
        w_drop_nxt = w_sel_blocked | (|w_sat_drop);
    end

    // Registered outputs so the counter sees glitch-free strobe and direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= 1'b0;
            up_down  <= 1'b1;
            drop_err <= 1'b0;
        end else begin
            count    <= w_count_nxt;
            up_down  <= w_up_down_nxt;
            drop_err <= w_drop_nxt;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_queue_sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue_sensor_ctrl
//  Description : Directed self-checking bench for queue_sensor_ctrl. A second
//                instance with DB_CYCLES=2 produces events fast enough to
//                starve the entry side and saturate its pending counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_sensor_ctrl;

    logic clk;
    logic reset_n;
    logic front, back, full, empty;
    logic count, up_down, busy, drop_err;
    logic front2, back2, full2, empty2;
    logic count2, up_down2, busy2, drop_err2;

    int checks = 0;
    int errors = 0;

    int ups1 = 0, downs1 = 0, drops1 = 0;
    int ups2 = 0, downs2 = 0, drops2 = 0;
    logic cnt_q1 = 1'b0, cnt_q2 = 1'b0;

    queue_sensor_ctrl #(.DB_CYCLES(4), .PEND_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .front_pcell(front),
        .back_pcell (back),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .up_down    (up_down),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    queue_sensor_ctrl #(.DB_CYCLES(2), .PEND_W(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .front_pcell(front2),
        .back_pcell (back2),
        .full       (full2),
        .empty      (empty2),
        .count      (count2),
        .up_down    (up_down2),
        .busy       (busy2),
        .drop_err   (drop_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally strobe rising edges by direction, and drop_err high cycles.
    always @(negedge clk) begin
        cnt_q1 <= count;
        cnt_q2 <= count2;
        if (count && !cnt_q1) begin
            if (up_down) ups1 <= ups1 + 1; else downs1 <= downs1 + 1;
        end
        if (count2 && !cnt_q2) begin
            if (up_down2) ups2 <= ups2 + 1; else downs2 <= downs2 + 1;
        end
        if (drop_err)  drops1 <= drops1 + 1;
        if (drop_err2) drops2 <= drops2 + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        front = 0; back = 0; full = 0; empty = 1;
        front2 = 0; back2 = 0; full2 = 0; empty2 = 0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_count",    count,    0);
        check("rst_up_down",  up_down,  1);
        check("rst_busy",     busy,     0);
        check("rst_drop_err", drop_err, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Single entry: strobe after edge 9, busy after edges 8..10.
        front = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("entry_count_%0d", i), count, (i == 9) ? 1 : 0);
            check($sformatf("entry_busy_%0d", i),  busy,  (i >= 8 && i <= 10) ? 1 : 0);
            if (i == 9) check("entry_up_down", up_down, 1);
        end
        front = 0;
        repeat (12) @(negedge clk);
        check("entry_ups", ups1, 1);

        // Glitch of 3 cycles on the exit cell must be ignored.
        empty = 0;
        back = 1;
        repeat (3) @(negedge clk);
        back = 0;
        repeat (14) @(negedge clk);
        check("glitch_downs", downs1, 0);
        check("glitch_drops", drops1, 0);
        check("glitch_busy",  busy,   0);

        // Simultaneous entry and exit: exit strobe after edge 9, entry after edge 13.
        front = 1; back = 1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check($sformatf("sim_count_%0d", i), count, (i == 9 || i == 13) ? 1 : 0);
            check($sformatf("sim_up_down_%0d", i), up_down, (i >= 8 && i <= 11) ? 0 : 1);
            check($sformatf("sim_busy_%0d", i), busy,
                  ((i >= 8 && i <= 10) || (i >= 12 && i <= 14)) ? 1 : 0);
        end
        front = 0; back = 0;
        repeat (12) @(negedge clk);
        check("sim_downs", downs1, 1);
        check("sim_ups",   ups1,   2);

        // Entry while full, then exit while empty: one drop each, no strobe.
        full = 1; empty = 1;
        front = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("full_drop_%0d", i),  drop_err, (i == 8) ? 1 : 0);
            check($sformatf("full_count_%0d", i), count, 0);
            check($sformatf("full_busy_%0d", i),  busy,  0);
        end
        front = 0;
        repeat (12) @(negedge clk);
        back = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("empty_drop_%0d", i),  drop_err, (i == 8) ? 1 : 0);
            check($sformatf("empty_count_%0d", i), count, 0);
        end
        back = 0;
        repeat (12) @(negedge clk);
        full = 0;
        check("bound_drops", drops1, 2);
        check("bound_ups",   ups1,   2);
        check("bound_downs", downs1, 1);

        // Reset during the exit PULSE discards the pending entry as well.
        empty = 0;
        front = 1; back = 1;
        repeat (9) @(negedge clk);
        check("pre_rst_count",   count,   1);
        check("pre_rst_up_down", up_down, 0);
        reset_n = 0; front = 0; back = 0;
        #1;
        check("mid_rst_count",   count,   0);
        check("mid_rst_busy",    busy,    0);
        check("mid_rst_up_down", up_down, 1);
        @(negedge clk);
        reset_n = 1;
        repeat (20) @(negedge clk);
        check("post_rst_downs", downs1, 2);
        check("post_rst_ups",   ups1,   2);
        check("post_rst_busy",  busy,   0);

        // After reset a fresh entry needs the full debounce again.
        front = 1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("rearm_count_%0d", i), count, (i == 9) ? 1 : 0);
        end
        front = 0;
        repeat (12) @(negedge clk);
        check("rearm_ups", ups1, 3);

        // Exits every 4 cycles keep the FSM busy; 4 entries saturate at 3.
        for (int p = 0; p < 5; p++) begin
            back2  = 1;
            front2 = (p < 4) ? 1'b1 : 1'b0;
            repeat (2) @(negedge clk);
            back2  = 0;
            front2 = 0;
            repeat (2) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check("sat_drops", drops2, 1);
        check("sat_downs", downs2, 5);
        check("sat_ups",   ups2,   3);
        check("sat_busy",  busy2,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
